// File: rtl/rle_flash_fetch.sv
// rtl/rle_flash_fetch.sv - SPI NOR continuous-read fetcher feeding 20-bit RLE words to the decoder
//
// Issues one READ (0x03) at START_ADDR and then streams indefinitely at SCK = clk/2.
// Incoming bits are packed MSB first into 20-bit words, with no byte alignment, and
// buffered in a FIFO_DEPTH-entry FIFO. SCK is held low at word boundaries while the
// FIFO is full. CS stays low during the stall, so the flash read remains open.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   restart    synchronous pulse: drop everything and re-issue the read from START_ADDR
//   spi_cs_n   flash chip select (active low)
//   spi_sck    flash serial clock, idle low (mode 0)
//   spi_mosi   command/address bits, MSB first
//   spi_miso   flash read data, MSB first
//   data_in    FIFO head word; holds the last popped word while empty
//   data_ready FIFO not empty
//   shift_data pop request from the decoder
module rle_flash_fetch #(
  parameter int          FIFO_DEPTH     = 4,
  parameter logic [23:0] START_ADDR     = 24'h000000,
  parameter int          CS_HIGH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        restart,
  output logic        spi_cs_n,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic [19:0] data_in,
  output logic        data_ready,
  input  logic        shift_data
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int IW = (CS_HIGH_CYCLES > 1) ? $clog2(CS_HIGH_CYCLES) : 1;
  localparam logic [7:0]    READ_CMD  = 8'h03;
  localparam logic [IW-1:0] IDLE_LAST = IW'(CS_HIGH_CYCLES - 1);
  localparam logic [PW:0]   FULL      = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CMD    = 2'd1,
    ADDR   = 2'd2,
    STREAM = 2'd3
  } state_t;

  state_t        state, state_next;
  logic          phase;      // 0: sck low / mosi set up, 1: sck high
  logic [4:0]    bit_cnt;    // bit index within command byte, address, or word
  logic [IW-1:0] idle_cnt;
  logic [23:0]   tx;         // outgoing command/address, mosi is bit 23
  logic [18:0]   shreg;      // first 19 bits of the word being assembled
  logic [19:0]   word;

  logic [19:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic [19:0]   last_word;

  logic active, stall, sample, push, pop;

  assign word = {shreg, spi_miso};

  always_comb begin
    active     = (state != IDLE);
    // Only a word's first bit may wait; a started word always completes.
    stall      = (state == STREAM) && !phase && (bit_cnt == 5'd0) && (count == FULL);
    sample     = active && phase;
    push       = sample && (state == STREAM) && (bit_cnt == 5'd19) && !restart;
    pop        = shift_data && (count != '0) && !restart;

    spi_cs_n   = (state == IDLE);
    spi_sck    = active && phase;
    spi_mosi   = ((state == CMD) || (state == ADDR)) ? tx[23] : 1'b0;
    data_ready = (count != '0);
    data_in    = data_ready ? mem[rd_ptr] : last_word;

    state_next = state;
    case (state)
      IDLE:    if (idle_cnt == IDLE_LAST) state_next = CMD;
      CMD:     if (sample && (bit_cnt == 5'd7))  state_next = ADDR;
      ADDR:    if (sample && (bit_cnt == 5'd23)) state_next = STREAM;
      STREAM:  state_next = STREAM;
      default: state_next = IDLE;
    endcase
    if (restart) state_next = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase     <= 1'b0;
      bit_cnt   <= '0;
      idle_cnt  <= '0;
      tx        <= '0;
      shreg     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      last_word <= '0;
    end else if (restart) begin
      // last_word is kept so data_in still shows the last word the decoder saw.
      phase    <= 1'b0;
      bit_cnt  <= '0;
      idle_cnt <= '0;
      tx       <= '0;
      shreg    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      if (state == IDLE) begin
        if (idle_cnt == IDLE_LAST) begin
          idle_cnt <= '0;
          tx       <= {READ_CMD, 16'h0000};
        end else begin
          idle_cnt <= idle_cnt + IW'(1);
        end
      end

      if (active && !stall) phase <= ~phase;

      if (sample) begin
        case (state)
          CMD: begin
            if (bit_cnt == 5'd7) begin
              bit_cnt <= '0;
              tx      <= START_ADDR;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
              tx      <= {tx[22:0], 1'b0};
            end
          end
          ADDR: begin
            bit_cnt <= (bit_cnt == 5'd23) ? 5'd0 : bit_cnt + 5'd1;
            tx      <= {tx[22:0], 1'b0};
          end
          STREAM: begin
            shreg   <= word[18:0];
            bit_cnt <= (bit_cnt == 5'd19) ? 5'd0 : bit_cnt + 5'd1;
          end
          default: ;
        endcase
      end

      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr    <= rd_ptr + PW'(1);
        last_word <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + (PW + 1)'(1);
        2'b01:   count <= count - (PW + 1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= word;
  end

endmodule

// File: tb/tb_rle_flash_fetch.sv
// tb/tb_rle_flash_fetch.sv - self-checking bench for rle_flash_fetch with a SPI NOR read model
module tb_rle_flash_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        restart = 1'b0;
  logic        shift_data = 1'b0;
  logic        spi_cs_n, spi_sck, spi_mosi;
  logic        miso = 1'b0;
  logic [19:0] data_in;
  logic        data_ready;

  int pass_cnt = 0;
  int check_cnt = 0;

  logic [19:0] sb[$];
  int          rx_bits = 0;
  logic [31:0] cmd_addr = '0;

  always #5 clk = ~clk;

  rle_flash_fetch dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .restart    (restart),
    .spi_cs_n   (spi_cs_n),
    .spi_sck    (spi_sck),
    .spi_mosi   (spi_mosi),
    .spi_miso   (miso),
    .data_in    (data_in),
    .data_ready (data_ready),
    .shift_data (shift_data)
  );

  function automatic logic [7:0] flash_byte(int a);
    case (a)
      0:       return 8'hAB;
      1:       return 8'hCD;
      2:       return 8'hE1;
      3:       return 8'h23;
      4:       return 8'h45;
      default: return 8'((a * 37 + 90) & 255);
    endcase
  endfunction

  function automatic logic flash_bit(int k);
    logic [7:0] b;
    b = flash_byte(k / 8);
    return b[7 - (k % 8)];
  endfunction

  function automatic logic [19:0] exp_word(int n);
    logic [19:0] w;
    w = '0;
    for (int j = 0; j < 20; j++) w = {w[18:0], flash_bit(20 * n + j)};
    return w;
  endfunction

  // Flash: capture command/address on rising SCK, reset on CS high.
  always @(posedge spi_cs_n or posedge spi_sck) begin
    if (spi_cs_n) begin
      rx_bits  = 0;
      cmd_addr = '0;
    end else begin
      if (rx_bits < 32) cmd_addr = {cmd_addr[30:0], spi_mosi};
      rx_bits++;
    end
  end

  // Flash: shift data out after falling SCK; expected word queued once its last bit is driven.
  always @(negedge spi_sck) begin
    int k;
    #1;
    if (!spi_cs_n && rx_bits >= 32) begin
      k = rx_bits - 32;
      miso = flash_bit(k);
      if (k % 20 == 19) sb.push_back(exp_word(k / 20));
    end
  end

  task automatic edges(int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; restart is sampled on the following posedge.
  task automatic do_restart();
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    sb.delete();
  endtask

  task automatic do_pop(output logic [19:0] got, output logic [19:0] exp);
    got = data_in;
    exp = (sb.size() > 0) ? sb.pop_front() : 20'hxxxxx;
    shift_data = 1'b1;
    @(negedge clk);
    shift_data = 1'b0;
  endtask

  task automatic test_reset();
    logic [19:0] got, exp;
    #1 rst_n = 1'b0;
    #2;
    check_cnt++; if (spi_cs_n !== 1'b1) $display("FAIL reset_cs_n got %b expected 1", spi_cs_n); else pass_cnt++;
    check_cnt++; if (spi_sck !== 1'b0) $display("FAIL reset_sck got %b expected 0", spi_sck); else pass_cnt++;
    check_cnt++; if (spi_mosi !== 1'b0) $display("FAIL reset_mosi got %b expected 0", spi_mosi); else pass_cnt++;
    check_cnt++; if (data_ready !== 1'b0) $display("FAIL reset_ready got %b expected 0", data_ready); else pass_cnt++;
    check_cnt++; if (data_in !== 20'h0) $display("FAIL reset_data got %h expected 00000", data_in); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    edges(1);
    check_cnt++; if (spi_cs_n !== 1'b1) $display("FAIL cs_high_edge1 got %b expected 1", spi_cs_n); else pass_cnt++;
    edges(1);
    check_cnt++; if (spi_cs_n !== 1'b0) $display("FAIL cs_fall_edge2 got %b expected 0", spi_cs_n); else pass_cnt++;
    edges(64);
    check_cnt++; if (cmd_addr !== 32'h03000000) $display("FAIL cmd_addr got %h expected 03000000", cmd_addr); else pass_cnt++;
    edges(39);
    check_cnt++; if (data_ready !== 1'b0) $display("FAIL ready_edge105 got %b expected 0", data_ready); else pass_cnt++;
    edges(1);
    check_cnt++; if (data_ready !== 1'b1) $display("FAIL ready_edge106 got %b expected 1", data_ready); else pass_cnt++;
    do_pop(got, exp);
    check_cnt++; if (got !== 20'hABCDE) $display("FAIL first_word got %h expected abcde", got); else pass_cnt++;
    check_cnt++; if (got !== exp) $display("FAIL first_word_sb got %h expected %h", got, exp); else pass_cnt++;
    edges(38);
    check_cnt++; if (data_ready !== 1'b0) $display("FAIL ready_edge145 got %b expected 0", data_ready); else pass_cnt++;
    edges(1);
    check_cnt++; if (data_ready !== 1'b1) $display("FAIL ready_edge146 got %b expected 1", data_ready); else pass_cnt++;
    do_pop(got, exp);
    check_cnt++; if (got !== 20'h12345) $display("FAIL second_word got %h expected 12345", got); else pass_cnt++;
    check_cnt++; if (got !== exp) $display("FAIL second_word_sb got %h expected %h", got, exp); else pass_cnt++;
  endtask

  task automatic test_stall();
    logic [19:0] got, exp;
    int sck_hi, cs_hi;
    do_restart();
    edges(259);
    sck_hi = 0;
    cs_hi = 0;
    repeat (1000) begin
      @(negedge clk);
      if (spi_sck) sck_hi++;
      if (spi_cs_n) cs_hi++;
    end
    check_cnt++; if (sck_hi !== 0) $display("FAIL stall_sck high_cycles %0d expected 0", sck_hi); else pass_cnt++;
    check_cnt++; if (cs_hi !== 0) $display("FAIL stall_cs_n high_cycles %0d expected 0", cs_hi); else pass_cnt++;
    do_pop(got, exp);
    check_cnt++; if (got !== exp) $display("FAIL stall_pop0 got %h expected %h", got, exp); else pass_cnt++;
    check_cnt++; if (spi_sck !== 1'b0) $display("FAIL stall_release_phase0 sck %b expected 0", spi_sck); else pass_cnt++;
    edges(1);
    check_cnt++; if (spi_sck !== 1'b1) $display("FAIL stall_release_sck sck %b expected 1", spi_sck); else pass_cnt++;
    for (int i = 1; i < 4; i++) begin
      do_pop(got, exp);
      check_cnt++; if (got !== exp) $display("FAIL stall_pop%0d got %h expected %h", i, got, exp); else pass_cnt++;
    end
    edges(35);
    check_cnt++; if (data_ready !== 1'b0) $display("FAIL stall_word5_early ready %b expected 0", data_ready); else pass_cnt++;
    edges(1);
    check_cnt++; if (data_ready !== 1'b1) $display("FAIL stall_word5_ready ready %b expected 1", data_ready); else pass_cnt++;
    do_pop(got, exp);
    check_cnt++; if (got !== exp) $display("FAIL stall_word5 got %h expected %h", got, exp); else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    logic [19:0] got, exp;
    do_restart();
    edges(185);
    for (int i = 0; i < 3; i++) begin
      do_pop(got, exp);
      check_cnt++; if (got !== exp) $display("FAIL simul_pop%0d got %h expected %h", i, got, exp); else pass_cnt++;
    end
    check_cnt++; if (data_ready !== 1'b0) $display("FAIL simul_empty ready %b expected 0", data_ready); else pass_cnt++;
  endtask

  task automatic test_empty_pop();
    logic [19:0] got, exp;
    int ready_hi;
    do_restart();
    shift_data = 1'b1;
    ready_hi = 0;
    repeat (105) begin
      @(negedge clk);
      if (data_ready) ready_hi++;
    end
    check_cnt++; if (ready_hi !== 0) $display("FAIL empty_ready high_cycles %0d expected 0", ready_hi); else pass_cnt++;
    edges(1);
    check_cnt++; if (data_ready !== 1'b1) $display("FAIL empty_first_ready got %b expected 1", data_ready); else pass_cnt++;
    exp = (sb.size() > 0) ? sb.pop_front() : 20'hxxxxx;
    check_cnt++; if (data_in !== exp) $display("FAIL empty_first_word got %h expected %h", data_in, exp); else pass_cnt++;
    edges(1);
    shift_data = 1'b0;
    check_cnt++; if (data_ready !== 1'b0) $display("FAIL empty_after_pop got %b expected 0", data_ready); else pass_cnt++;
    edges(39);
    check_cnt++; if (data_ready !== 1'b1) $display("FAIL empty_second_ready got %b expected 1", data_ready); else pass_cnt++;
    do_pop(got, exp);
    check_cnt++; if (got !== exp) $display("FAIL empty_second_word got %h expected %h", got, exp); else pass_cnt++;
  endtask

  task automatic test_restart();
    logic [19:0] got, exp;
    do_restart();
    edges(199);
    check_cnt++; if (data_ready !== 1'b1) $display("FAIL rst_pre_ready got %b expected 1", data_ready); else pass_cnt++;
    do_restart();
    check_cnt++; if (spi_cs_n !== 1'b1) $display("FAIL restart_cs_n got %b expected 1", spi_cs_n); else pass_cnt++;
    check_cnt++; if (spi_sck !== 1'b0) $display("FAIL restart_sck got %b expected 0", spi_sck); else pass_cnt++;
    check_cnt++; if (data_ready !== 1'b0) $display("FAIL restart_flush got %b expected 0", data_ready); else pass_cnt++;
    edges(1);
    check_cnt++; if (spi_cs_n !== 1'b1) $display("FAIL restart_cs_hold got %b expected 1", spi_cs_n); else pass_cnt++;
    edges(1);
    check_cnt++; if (spi_cs_n !== 1'b0) $display("FAIL restart_cs_fall got %b expected 0", spi_cs_n); else pass_cnt++;
    edges(64);
    check_cnt++; if (cmd_addr !== 32'h03000000) $display("FAIL restart_cmd_addr got %h expected 03000000", cmd_addr); else pass_cnt++;
    edges(40);
    check_cnt++; if (data_ready !== 1'b1) $display("FAIL restart_ready got %b expected 1", data_ready); else pass_cnt++;
    do_pop(got, exp);
    check_cnt++; if (got !== 20'hABCDE) $display("FAIL restart_first_word got %h expected abcde", got); else pass_cnt++;
    check_cnt++; if (got !== exp) $display("FAIL restart_first_word_sb got %h expected %h", got, exp); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    logic [19:0] got, exp;
    do_restart();
    edges(30);
    #2 rst_n = 1'b0;
    #1;
    check_cnt++; if (spi_cs_n !== 1'b1) $display("FAIL areset_cs_n got %b expected 1", spi_cs_n); else pass_cnt++;
    check_cnt++; if (spi_sck !== 1'b0) $display("FAIL areset_sck got %b expected 0", spi_sck); else pass_cnt++;
    check_cnt++; if (spi_mosi !== 1'b0) $display("FAIL areset_mosi got %b expected 0", spi_mosi); else pass_cnt++;
    check_cnt++; if (data_in !== 20'h0) $display("FAIL areset_data got %h expected 00000", data_in); else pass_cnt++;
    check_cnt++; if (rx_bits !== 0) $display("FAIL areset_flash_deselect bits %0d expected 0", rx_bits); else pass_cnt++;
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    edges(66);
    check_cnt++; if (cmd_addr !== 32'h03000000) $display("FAIL areset_cmd_addr got %h expected 03000000", cmd_addr); else pass_cnt++;
    edges(40);
    check_cnt++; if (data_ready !== 1'b1) $display("FAIL areset_ready got %b expected 1", data_ready); else pass_cnt++;
    do_pop(got, exp);
    check_cnt++; if (got !== 20'hABCDE) $display("FAIL areset_first_word got %h expected abcde", got); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_stall();
    test_simultaneous();
    test_empty_pop();
    test_restart();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/rle_flash_fetch.md
Name: rle_flash_fetch

Overview:
- Upstream feeder for the RLE video decoder.
- Streams packed 20-bit RLE words from an external SPI NOR flash using a continuous READ (0x03) at SCK = clk/2.
- Buffers the words in a small FIFO and presents them on a data_in/data_ready/shift_data handshake.
- Stalls SCK when the FIFO cannot accept another word, so the decoder's bursty consumption during blanking never loses data.

Parameters:
- FIFO_DEPTH, 4: number of 20-bit words buffered; power of two, 2..16.
- START_ADDR, 24'h000000: flash byte address where the RLE stream begins.
- CS_HIGH_CYCLES, 2: minimum clk cycles spi_cs_n is held high before a new command.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- restart  input  1  synchronous pulse; aborts the current read and restarts the stream from START_ADDR.
- spi_cs_n  output  1  flash chip select, active low.
- spi_sck  output  1  flash serial clock, idle low (SPI mode 0).
- spi_mosi  output  1  command/address bits, MSB first.
- spi_miso  input  1  flash data, MSB first.
- data_in  output  20  FIFO head word (decoder input).
- data_ready  output  1  FIFO not empty.
- shift_data  input  1  pop request from the decoder.

Behaviour:
- Reset (async, rst_n low):
  - spi_cs_n=1, spi_sck=0, spi_mosi=0, data_in=0, data_ready=0.
  - FIFO empty, state=IDLE, cs-high counter cleared.
- States: IDLE -> CMD -> ADDR -> STREAM; restart returns to IDLE from any state.
- IDLE:
  - cs_n=1, sck=0.
  - Counts CS_HIGH_CYCLES clk edges, then enters CMD with cs_n=0.
- Bit timing (every SPI bit is 2 clk cycles):
  - Phase 0: sck=0, mosi holds the bit.
  - Phase 1: sck=1.
  - miso is sampled on the clk edge that ends phase 1, as sck returns low.
- CMD: shifts 8'h03 MSB first; 16 cycles.
- ADDR: shifts START_ADDR MSB first; 48 cycles; then STREAM. mosi=0 in STREAM.
- STREAM, assembly:
  - Sampled bits shift into a 20-bit register MSB first.
  - Words are packed back-to-back across byte boundaries, with no padding.
  - When the 20th bit is sampled, the word is pushed into the FIFO in the same edge and the bit counter resets to 0.
- STREAM, stall:
  - Before phase 0 of a word's first bit, if the FIFO count equals FIFO_DEPTH, sck stays 0 and cs_n stays 0 (the flash read is held open) until count < FIFO_DEPTH.
  - Stalls occur only at word boundaries, never mid-word.
  - Only this block pushes, so a push can never overflow the FIFO.
- Flash addressing: the read is never terminated except by restart or reset; the flash auto-increments and wraps.
- FIFO, pop:
  - data_in is the head word, valid combinationally whenever data_ready=1.
  - shift_data with data_ready=1 pops the head on that edge.
  - shift_data with data_ready=0 is ignored. There is no underflow and no state change.
  - When the FIFO is empty, data_in holds its last value (0 after reset).
- FIFO, simultaneous events:
  - Push and pop in the same edge leave the count unchanged.
  - A push into an empty FIFO makes data_ready=1 on the next cycle. There is no fall-through in the push cycle.
- restart:
  - Sampled on a clk edge.
  - Next cycle: cs_n=1, sck=0, FIFO flushed (data_ready=0), partial word discarded, state=IDLE.
  - restart asserted during IDLE restarts the CS_HIGH_CYCLES count.
  - restart takes priority over a simultaneous push or pop.
- Startup latency: counting from the first edge with rst_n high, data_ready first rises CS_HIGH_CYCLES+104 edges later (CMD+ADDR = 64, one word = 40). This is 106 with defaults.
- Sustained throughput: one word per 40 clk cycles.

Test Plan:
- Reset release; flash model returns 0xABCDE12345... -> cs_n falls at edge 2; mosi shows 0x03 then 0x000000 over 64 cycles; data_ready rises at edge 106 with data_in=20'hABCDE; the second word is 20'h12345 at edge 146.
- Never assert shift_data -> after 4 words, count=4; sck stays 0 and cs_n stays 0 for 1000 cycles; single shift_data pop -> sck resumes on the next cycle; the 5th word arrives 40 cycles later, correct and with no lost bits.
- shift_data asserted on the same edge a word is pushed with count=2 -> count stays 2; pop order matches stream order.
- shift_data held high with FIFO empty -> data_ready stays 0; no pointer corruption; the next pushed word is read correctly.
- restart mid-word in STREAM with 3 words buffered -> next cycle cs_n=1 and data_ready=0; CMD/ADDR is reissued after 2 cycles; the first word after restart equals the first word of the stream.
- rst_n asserted mid-ADDR -> outputs immediately take reset values, asynchronously before the next clk edge; after release the full command is resent from the beginning.
